// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 16-step shift-add
// multiplier, and the EX/MEM pipeline register feeding MEM.
module ex_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM8_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] rd1E_i,
  input  logic [DATA_WIDTH-1:0] rd2E_i,
  input  logic [IMM8_WIDTH-1:0] imm8E_i,
  input  logic [REG_WIDTH-1:0]  rsE_i,
  input  logic [REG_WIDTH-1:0]  WriteRegE_i,
  input  logic [OP_WIDTH-1:0]   AluOpE_i,
  input  logic                  AluSrcE_i,
  input  logic                  RegWriteE_i,
  input  logic                  BranchE_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic                  MemToRegE_i,
  input  logic                  MovE_i,
  input  logic [1:0]            ForwardAE_i,
  input  logic [1:0]            ForwardBE_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_fwd_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  stall_EX_MEM_i,
  input  logic                  flush_EX_MEM_i,
  output logic                  mul_busy_o,
  output logic [ADDR_WIDTH-1:0] PCM_o,
  output logic [DATA_WIDTH-1:0] alu_outM_o,
  output logic [DATA_WIDTH-1:0] WriteDataM_o,
  output logic [IMM8_WIDTH-1:0] imm8M_o,
  output logic [REG_WIDTH-1:0]  rsM_o,
  output logic [REG_WIDTH-1:0]  WriteRegM_o,
  output logic                  RegWriteM_o,
  output logic                  BranchM_o,
  output logic                  MemReadM_o,
  output logic                  MemWriteM_o,
  output logic                  MemToRegM_o,
  output logic                  MovM_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplr;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_wd;
  logic [IMM8_WIDTH-1:0] r_imm;
  logic [REG_WIDTH-1:0]  r_rs;
  logic [REG_WIDTH-1:0]  r_wr;
  logic [5:0]            r_ctl;

  logic [DATA_WIDTH-1:0] w_srcA;
  logic [DATA_WIDTH-1:0] w_fwdB;
  logic [DATA_WIDTH-1:0] w_srcB;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [5:0]            w_ctl;
  logic                  w_mul_op;
  logic                  w_busy;

  always_comb begin
    w_srcA = rd1E_i;
    case (ForwardAE_i)
      2'b01:   w_srcA = ResultW_i;
      2'b10:   w_srcA = alu_outM_fwd_i;
      default: w_srcA = rd1E_i;
    endcase
  end

  always_comb begin
    w_fwdB = rd2E_i;
    case (ForwardBE_i)
      2'b01:   w_fwdB = ResultW_i;
      2'b10:   w_fwdB = alu_outM_fwd_i;
      default: w_fwdB = rd2E_i;
    endcase
  end

  assign w_srcB = AluSrcE_i
    ? {{(DATA_WIDTH-IMM8_WIDTH){imm8E_i[IMM8_WIDTH-1]}}, imm8E_i}
    : w_fwdB;

  // The finished product only appears in DONE; MUL in other states is a bubble.
  always_comb begin
    w_alu = w_srcB;
    if (r_state == S_DONE) begin
      w_alu = r_acc;
    end else begin
      case (AluOpE_i)
        OP_ADD:  w_alu = w_srcA + w_srcB;
        OP_SUB:  w_alu = w_srcA - w_srcB;
        OP_AND:  w_alu = w_srcA & w_srcB;
        OP_OR:   w_alu = w_srcA | w_srcB;
        OP_XOR:  w_alu = w_srcA ^ w_srcB;
        OP_SLL:  w_alu = w_srcA << w_srcB[CW-1:0];
        OP_SRL:  w_alu = w_srcA >> w_srcB[CW-1:0];
        OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}},
                          $signed(w_srcA) < $signed(w_srcB)};
        OP_MUL:  w_alu = r_acc;
        default: w_alu = w_srcB;
      endcase
    end
  end

  assign w_mul_op = (AluOpE_i == OP_MUL);
  assign w_busy   = !flush_EX_MEM_i &&
                    ((r_state == S_IDLE && w_mul_op) || r_state == S_MUL);
  assign mul_busy_o = w_busy;

  assign w_ctl = {RegWriteE_i, BranchE_i, MemReadE_i,
                  MemWriteE_i, MemToRegE_i, MovE_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (flush_EX_MEM_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (!stall_EX_MEM_i) begin
      unique case (r_state)
        S_IDLE: if (w_mul_op) begin
          r_mcand <= w_srcA;
          r_mplr  <= w_srcB;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_MUL;
        end
        S_MUL: begin
          if (r_mplr[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data fields still load while busy; only the controls are bubbled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_alu <= '0;
      r_wd  <= '0;
      r_imm <= '0;
      r_rs  <= '0;
      r_wr  <= '0;
      r_ctl <= '0;
    end else if (flush_EX_MEM_i) begin
      r_pc  <= '0;
      r_alu <= '0;
      r_wd  <= '0;
      r_imm <= '0;
      r_rs  <= '0;
      r_wr  <= '0;
      r_ctl <= '0;
    end else if (!stall_EX_MEM_i) begin
      r_pc  <= PCE_i;
      r_alu <= w_alu;
      r_wd  <= w_fwdB;
      r_imm <= imm8E_i;
      r_rs  <= rsE_i;
      r_wr  <= WriteRegE_i;
      r_ctl <= w_busy ? 6'b0 : w_ctl;
    end
  end

  assign PCM_o        = r_pc;
  assign alu_outM_o   = r_alu;
  assign WriteDataM_o = r_wd;
  assign imm8M_o      = r_imm;
  assign rsM_o        = r_rs;
  assign WriteRegM_o  = r_wr;
  assign {RegWriteM_o, BranchM_o, MemReadM_o,
          MemWriteM_o, MemToRegM_o, MovM_o} = r_ctl;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and random instructions; expected EX/MEM
// bundles are queued at issue and popped by an independent monitor.
`timescale 1ns/1ps
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCE_i;
  logic [15:0] rd1E_i, rd2E_i;
  logic [7:0]  imm8E_i;
  logic [3:0]  rsE_i, WriteRegE_i, AluOpE_i;
  logic        AluSrcE_i;
  logic        RegWriteE_i, BranchE_i, MemReadE_i;
  logic        MemWriteE_i, MemToRegE_i, MovE_i;
  logic [1:0]  ForwardAE_i, ForwardBE_i;
  logic [15:0] alu_outM_fwd_i, ResultW_i;
  logic        stall_EX_MEM_i, flush_EX_MEM_i;
  logic        mul_busy_o;
  logic [7:0]  PCM_o;
  logic [15:0] alu_outM_o, WriteDataM_o;
  logic [7:0]  imm8M_o;
  logic [3:0]  rsM_o, WriteRegM_o;
  logic        RegWriteM_o, BranchM_o, MemReadM_o;
  logic        MemWriteM_o, MemToRegM_o, MovM_o;
  logic [5:0]  e_ctl;

  always #5 clk = ~clk;

  assign {RegWriteE_i, BranchE_i, MemReadE_i,
          MemWriteE_i, MemToRegE_i, MovE_i} = e_ctl;

  ex_stage dut (
    .clk(clk), .rst(rst), .PCE_i(PCE_i),
    .rd1E_i(rd1E_i), .rd2E_i(rd2E_i), .imm8E_i(imm8E_i),
    .rsE_i(rsE_i), .WriteRegE_i(WriteRegE_i), .AluOpE_i(AluOpE_i),
    .AluSrcE_i(AluSrcE_i), .RegWriteE_i(RegWriteE_i),
    .BranchE_i(BranchE_i), .MemReadE_i(MemReadE_i),
    .MemWriteE_i(MemWriteE_i), .MemToRegE_i(MemToRegE_i),
    .MovE_i(MovE_i), .ForwardAE_i(ForwardAE_i),
    .ForwardBE_i(ForwardBE_i), .alu_outM_fwd_i(alu_outM_fwd_i),
    .ResultW_i(ResultW_i), .stall_EX_MEM_i(stall_EX_MEM_i),
    .flush_EX_MEM_i(flush_EX_MEM_i), .mul_busy_o(mul_busy_o),
    .PCM_o(PCM_o), .alu_outM_o(alu_outM_o),
    .WriteDataM_o(WriteDataM_o), .imm8M_o(imm8M_o), .rsM_o(rsM_o),
    .WriteRegM_o(WriteRegM_o), .RegWriteM_o(RegWriteM_o),
    .BranchM_o(BranchM_o), .MemReadM_o(MemReadM_o),
    .MemWriteM_o(MemWriteM_o), .MemToRegM_o(MemToRegM_o),
    .MovM_o(MovM_o)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [7:0]  imm;
    logic [3:0]  rs;
    logic [3:0]  wr;
    logic [5:0]  ctl;
  } exm_t;

  exm_t sb[$];
  exm_t cur, prev_out;
  int   checks = 0;
  int   fails  = 0;
  logic mon_stall = 1'b0;
  bit   mon_en = 1'b0;

  assign cur = {PCM_o, alu_outM_o, WriteDataM_o, imm8M_o, rsM_o,
                WriteRegM_o, RegWriteM_o, BranchM_o, MemReadM_o,
                MemWriteM_o, MemToRegM_o, MovM_o};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fsel(input logic [1:0] s,
      input logic [15:0] rv, input logic [15:0] w, input logic [15:0] m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return rv;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [3:0] op,
      input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    int sa, sb2;
    sa  = int'($signed(a));
    sb2 = int'($signed(b));
    p   = {16'b0, a} * {16'b0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << (b % 16);
      4'd6: return a >> (b % 16);
      4'd7: return (sa < sb2) ? 16'd1 : 16'd0;
      4'd8: return p[15:0];
      default: return b;
    endcase
  endfunction

  always @(posedge clk) mon_stall <= stall_EX_MEM_i && !flush_EX_MEM_i;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mon_stall) begin
        chk("hold", cur, prev_out);
      end else if (RegWriteM_o) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", cur);
        end else begin
          chk("exmem", cur, sb.pop_front());
        end
      end else begin
        chk("bubble_ctl", cur.ctl, 6'b0);
      end
      prev_out = cur;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] r1,
      input logic [15:0] r2, input logic [15:0] rw, input logic [15:0] am,
      input logic [7:0] imm, input logic [1:0] fa, input logic [1:0] fb,
      input logic asrc, input int st_at, input int st_len);
    logic [15:0] a, bf, b;
    logic [7:0]  pc;
    logic [3:0]  rs, wr;
    logic [5:0]  ctl;
    exm_t        e;
    bit          ismul;
    int          total;
    pc  = 8'($urandom);
    rs  = 4'($urandom);
    wr  = 4'($urandom);
    ctl = {1'b1, 5'($urandom)};
    a   = fsel(fa, r1, rw, am);
    bf  = fsel(fb, r2, rw, am);
    b   = asrc ? {{8{imm[7]}}, imm} : bf;
    e   = '{pc: pc, alu: ref_alu(op, a, b), wd: bf, imm: imm,
            rs: rs, wr: wr, ctl: ctl};
    sb.push_back(e);
    ismul = (op == 4'd8);
    total = (ismul ? 18 : 1) + st_len;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      AluOpE_i = op; PCE_i = pc; imm8E_i = imm;
      rsE_i = rs; WriteRegE_i = wr; e_ctl = ctl;
      ForwardAE_i = fa; ForwardBE_i = fb; AluSrcE_i = asrc;
      flush_EX_MEM_i = 1'b0;
      stall_EX_MEM_i = (c >= st_at) && (c < st_at + st_len);
      if (ismul && c > 0 && c < total - 1) begin
        rd1E_i = 16'($urandom); rd2E_i = 16'($urandom);
        ResultW_i = 16'($urandom); alu_outM_fwd_i = 16'($urandom);
      end else begin
        rd1E_i = r1; rd2E_i = r2; ResultW_i = rw; alu_outM_fwd_i = am;
      end
      #1;
      chk("busy", mul_busy_o, ismul && (c < 17 + st_len));
    end
  endtask

  task automatic flush_mul(input int at);
    for (int c = 0; c <= at; c++) begin
      @(negedge clk);
      AluOpE_i = 4'd8; e_ctl = 6'b100000; PCE_i = 8'h33;
      rd1E_i = 16'h0123; rd2E_i = 16'h0045; AluSrcE_i = 1'b0;
      ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
      stall_EX_MEM_i = 1'b0;
      flush_EX_MEM_i = (c == at);
      #1;
      chk("busy_flush", mul_busy_o, c < at);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    AluOpE_i = 4'd0; e_ctl = 6'b0;
    stall_EX_MEM_i = 1'b0; flush_EX_MEM_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    int st_at, st_len;
    rst = 1'b1; e_ctl = 6'b0; PCE_i = 8'h0; rd1E_i = 16'h0; rd2E_i = 16'h0;
    imm8E_i = 8'h0; rsE_i = 4'h0; WriteRegE_i = 4'h0; AluOpE_i = 4'h0;
    AluSrcE_i = 1'b0; ForwardAE_i = 2'b0; ForwardBE_i = 2'b0;
    alu_outM_fwd_i = 16'h0; ResultW_i = 16'h0;
    stall_EX_MEM_i = 1'b0; flush_EX_MEM_i = 1'b0;
    #12;
    chk("rst_out", cur, 0);
    chk("rst_busy", mul_busy_o, 0);
    #5 rst = 1'b0;
    mon_en = 1'b1;

    issue(4'd0, 16'h1111, 16'h0005, 16'h0, 16'h0010, 8'h00,
          2'b10, 2'b00, 1'b0, -1, 0);
    issue(4'd7, 16'hFFFF, 16'h0, 16'h0, 16'h0, 8'h01,
          2'b00, 2'b00, 1'b1, -1, 0);
    issue(4'd6, 16'h8000, 16'h0, 16'h0, 16'h0, 8'h0F,
          2'b00, 2'b00, 1'b1, -1, 0);
    issue(4'd8, 16'h0123, 16'h0045, 16'h0, 16'h0, 8'h00,
          2'b00, 2'b00, 1'b0, -1, 0);
    issue(4'd8, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 8'h00,
          2'b01, 2'b10, 1'b0, -1, 0);
    flush_mul(6);
    issue(4'd0, 16'h2222, 16'h0005, 16'h0, 16'h0010, 8'h00,
          2'b10, 2'b00, 1'b0, -1, 0);
    issue(4'd8, 16'h0123, 16'h0045, 16'h0, 16'h0, 8'h00,
          2'b00, 2'b00, 1'b0, 5, 3);
    issue(4'd1, 16'h0003, 16'h0009, 16'h0, 16'h0, 8'h00,
          2'b00, 2'b00, 1'b0, 0, 2);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) op = 4'd8;
      st_at = -1; st_len = 0;
      if (op == 4'd8 && $urandom_range(0, 3) == 0) begin
        st_at = $urandom_range(0, 16); st_len = $urandom_range(1, 3);
      end else if (op != 4'd8 && $urandom_range(0, 4) == 0) begin
        st_at = 0; st_len = $urandom_range(1, 2);
      end
      issue(op, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), st_at, st_len);
    end

    @(negedge clk);
    AluOpE_i = 4'd8; e_ctl = 6'b100000; PCE_i = 8'h5A;
    rd1E_i = 16'h0003; rd2E_i = 16'h0004; AluSrcE_i = 1'b0;
    ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
    stall_EX_MEM_i = 1'b0; flush_EX_MEM_i = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", cur, 0);
    @(negedge clk);
    AluOpE_i = 4'd0; e_ctl = 6'b0;
    #1 chk("busy_after_rst", mul_busy_o, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    issue(4'd4, 16'h00F0, 16'h0FF0, 16'h0, 16'h0, 8'h00,
          2'b00, 2'b00, 1'b0, -1, 0);
    issue(4'd5, 16'h0001, 16'h0, 16'h0, 16'h0, 8'h0F,
          2'b00, 2'b00, 1'b1, -1, 0);
    idle();
    repeat (3) @(negedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipelined processor. Sits between the ID/EX register and the MEM stage, and owns the EX/MEM pipeline register that drives MEM.
- Performs operand forwarding, the single-cycle ALU ops, and an iterative 16-cycle shift-add multiply.
- While a multiply is in progress it raises a stall request toward the hazard unit.

Parameters:
- DATA_WIDTH, 16, datapath width
- ADDR_WIDTH, 8, PC / data-memory address width
- IMM8_WIDTH, 8, immediate field width
- REG_WIDTH, 4, register index width
- OP_WIDTH, 4, ALU opcode width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- PCE_i  in  ADDR_WIDTH  PC of the instruction in EX
- rd1E_i, rd2E_i  in  DATA_WIDTH  register-file read data
- imm8E_i  in  IMM8_WIDTH  immediate
- rsE_i, WriteRegE_i  in  REG_WIDTH  source and destination register indices
- AluOpE_i  in  OP_WIDTH  ALU opcode
- AluSrcE_i  in  1  1 = operand B is sign-extended imm8
- RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i  in  1 each  control bits
- ForwardAE_i, ForwardBE_i  in  2  forwarding selects: 00 register, 01 ResultW_i, 10 alu_outM_fwd_i, 11 register
- alu_outM_fwd_i  in  DATA_WIDTH  forwarded ALU result from MEM
- ResultW_i  in  DATA_WIDTH  forwarded write-back result
- stall_EX_MEM_i  in  1  hold the EX/MEM register and the FSM
- flush_EX_MEM_i  in  1  insert a bubble and abort any multiply
- mul_busy_o  out  1  stall request to IF/ID/ID-EX
- PCM_o, alu_outM_o, WriteDataM_o, imm8M_o, rsM_o, WriteRegM_o  out  matching widths  EX/MEM data
- RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o  out  1 each  EX/MEM controls

Behaviour:
- Operand selection:
  - srcA = fwd(ForwardAE_i, rd1E_i).
  - fwdB = fwd(ForwardBE_i, rd2E_i).
  - srcB = AluSrcE_i ? {{8{imm8E_i[7]}}, imm8E_i} : fwdB.
  - WriteData passed to MEM = fwdB.
- ALU opcodes, all results truncated to 16 bits:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL by srcB[3:0], 6 SRL (logical) by srcB[3:0].
  - 7 SLT signed, result 1 or 0.
  - 8 MUL, low 16 bits of the product.
  - 9-15 pass srcB.
- FSM states: IDLE, MUL, DONE.
  - IDLE: if AluOpE_i==8 and no flush, latch srcA into multiplicand and srcB into multiplier, clear accumulator, cnt=0, go to MUL. Otherwise stay in IDLE.
  - MUL: per cycle, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++. After the iteration with cnt==15, go to DONE.
  - DONE: acc is the ALU result this cycle; go to IDLE.
- mul_busy_o = (IDLE && AluOpE_i==8 && !flush) || MUL. It is combinational, and is 0 in DONE so the upstream pipeline advances exactly once.
- MUL latency: issue cycle T, busy for cycles T..T+16 (17 cycles), DONE in T+17, product in EX/MEM after the T+17 edge.
- EX/MEM register, priority rst > flush > stall > busy > load:
  - rst (asynchronous): all outputs 0, FSM to IDLE, cnt=0, acc=0.
  - flush: all six controls 0, data registers don't-care (cleared to 0), FSM to IDLE, busy drops the same cycle.
  - stall: all EX/MEM outputs hold; FSM state, cnt and acc hold; operand forwarding is not re-sampled.
  - busy (no stall): bubble loaded, controls 0.
  - otherwise: load alu result, fwdB, PCE_i, imm8E_i, rsE_i, WriteRegE_i and controls.
- Operands for MUL are captured only at issue. Later changes on the forwarding inputs do not affect the product.
- Reset deasserted mid-cycle: the first capture occurs on the next rising edge.

Test Plan:
- ADD with ForwardAE=10 (alu_outM_fwd_i=0x0010), rd2=0x0005 -> alu_outM_o=0x0015 one cycle later, RegWriteM_o follows RegWriteE_i.
- SLT with srcA=0xFFFF, imm8=0x01, AluSrcE=1 -> alu_outM_o=0x0001. SRL 0x8000 by 15 -> 0x0001.
- MUL 0x0123 x 0x0045 issued at T -> mul_busy_o high T..T+16, EX/MEM controls 0 during busy, alu_outM_o=0x4E6F after the T+17 edge with RegWriteM_o=1. Also MUL 0xFFFF x 0xFFFF -> 0x0001.
- flush_EX_MEM_i pulsed at busy cycle 6 -> busy low the same cycle, FSM IDLE, next instruction ADD executes normally.
- stall_EX_MEM_i held 3 cycles mid-MUL -> outputs and cnt frozen, total busy = 20 cycles, product still correct.
- rst asserted asynchronously between clock edges during MUL -> all outputs 0 immediately, mul_busy_o=0 after release with a non-MUL op.
